// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - video/CPU/RAM signal bundle for the character RAM arbiter
interface vram_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 8
);
    logic          v_req;
    logic [AW-1:0] v_addr;
    logic          v_valid;
    logic [DW-1:0] v_data;
    logic          v_overrun;

    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic          c_ack;
    logic [DW-1:0] c_rdata;

    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d;
    logic          mem_w;
    logic [DW-1:0] mem_q;

    // Environment side: video fetcher, CPU bus and the RAM itself
    modport master (
        output v_req, v_addr, c_req, c_we, c_addr, c_wdata, mem_q,
        input  v_valid, v_data, v_overrun, c_ack, c_rdata, mem_a, mem_d, mem_w
    );

    modport slave (
        input  v_req, v_addr, c_req, c_we, c_addr, c_wdata, mem_q,
        output v_valid, v_data, v_overrun, c_ack, c_rdata, mem_a, mem_d, mem_w
    );
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - fixed-priority video/CPU arbiter for one single-port character RAM port
module vram_arbiter #(
    parameter int AW     = 12,
    parameter int DW     = 8,
    parameter int STARVE = 4
) (
    input  logic          clock,
    input  logic          reset,
    vram_arbiter_if.slave bus
);
    localparam logic [7:0] STARVE_L = 8'(STARVE);

    logic          v_pend_q,    v_pend_d;
    logic [AW-1:0] v_addr_q,    v_addr_d;
    logic          v_overrun_q, v_overrun_d;
    logic          c_busy_q,    c_busy_d;
    logic [7:0]    starve_q,    starve_d;
    logic [AW-1:0] mem_a_q,     mem_a_d;
    logic [DW-1:0] mem_d_q,     mem_d_d;
    logic          mem_w_q,     mem_w_d;
    logic          tag_v_q,     tag_v_d;
    logic          tag_c_q,     tag_c_d;
    logic          v_valid_q,   v_valid_d;
    logic          c_ack_q,     c_ack_d;

    logic          v_cand;
    logic [AW-1:0] v_gaddr;
    logic          c_pend;
    logic          grant_v;
    logic          grant_c;

    always_comb begin
        // A fresh v_req can be granted straight away when the slot is empty
        v_cand  = v_pend_q | bus.v_req;
        v_gaddr = v_pend_q ? v_addr_q : bus.v_addr;
        c_pend  = bus.c_req & ~c_busy_q & ~c_ack_q;
        grant_v = v_cand & (~c_pend | (starve_q < STARVE_L));
        grant_c = c_pend & ~grant_v;

        v_pend_d    = v_pend_q;
        v_addr_d    = v_addr_q;
        v_overrun_d = v_overrun_q;
        if (bus.v_req) begin
            if (v_pend_q) begin
                v_pend_d = 1'b1;
                v_addr_d = bus.v_addr;
                if (!grant_v) begin
                    v_overrun_d = 1'b1;
                end
            end else if (!grant_v) begin
                v_pend_d = 1'b1;
                v_addr_d = bus.v_addr;
            end
        end else if (grant_v) begin
            v_pend_d = 1'b0;
        end

        starve_d = (c_pend && grant_v) ? starve_q + 8'd1 : 8'd0;
        c_busy_d = grant_c ? 1'b1 : (c_ack_q ? 1'b0 : c_busy_q);

        mem_a_d = mem_a_q;
        mem_d_d = mem_d_q;
        mem_w_d = 1'b0;
        if (grant_v) begin
            mem_a_d = v_gaddr;
        end else if (grant_c) begin
            mem_a_d = bus.c_addr;
            mem_d_d = bus.c_wdata;
            mem_w_d = bus.c_we;
        end

        // Return tag travels with mem_a; RAM data lands one cycle later
        tag_v_d   = grant_v;
        tag_c_d   = grant_c;
        v_valid_d = tag_v_q;
        c_ack_d   = tag_c_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v_pend_q    <= 1'b0;
            v_addr_q    <= '0;
            v_overrun_q <= 1'b0;
            c_busy_q    <= 1'b0;
            starve_q    <= 8'd0;
            mem_a_q     <= '0;
            mem_d_q     <= '0;
            mem_w_q     <= 1'b0;
            tag_v_q     <= 1'b0;
            tag_c_q     <= 1'b0;
            v_valid_q   <= 1'b0;
            c_ack_q     <= 1'b0;
        end else begin
            v_pend_q    <= v_pend_d;
            v_addr_q    <= v_addr_d;
            v_overrun_q <= v_overrun_d;
            c_busy_q    <= c_busy_d;
            starve_q    <= starve_d;
            mem_a_q     <= mem_a_d;
            mem_d_q     <= mem_d_d;
            mem_w_q     <= mem_w_d;
            tag_v_q     <= tag_v_d;
            tag_c_q     <= tag_c_d;
            v_valid_q   <= v_valid_d;
            c_ack_q     <= c_ack_d;
        end
    end

    assign bus.v_valid   = v_valid_q;
    assign bus.v_data    = bus.mem_q;
    assign bus.v_overrun = v_overrun_q;
    assign bus.c_ack     = c_ack_q;
    assign bus.c_rdata   = bus.mem_q;
    assign bus.mem_a     = mem_a_q;
    assign bus.mem_d     = mem_d_q;
    assign bus.mem_w     = mem_w_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed-vector bench for vram_arbiter with a registered-output RAM model
module tb_vram_arbiter;
    localparam int AW = 12;
    localparam int DW = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    vram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    vram_arbiter #(.AW(AW), .DW(DW), .STARVE(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] ram [0:(1<<AW)-1];

    function automatic logic [7:0] ram_init(input logic [11:0] a);
        return (a == 12'h123) ? 8'h41 : (a[7:0] ^ 8'h5A);
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] <= ram_init(12'(i));
        end else if (bus.mem_w) begin
            ram[bus.mem_a] <= bus.mem_d;
        end
        bus.mem_q <= ram[bus.mem_a];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Starvation/overrun stream: expected mem_a per cycle and output pulses
    logic [11:0] exp_ma [0:15];
    logic [15:0] exp_vv;
    logic [15:0] exp_ca;

    initial begin
        exp_ma = '{12'h000, 12'h200, 12'h201, 12'h202, 12'h203, 12'h010, 12'h204, 12'h205,
                   12'h206, 12'h207, 12'h208, 12'h209, 12'h010, 12'h002, 12'h002, 12'h002};
        exp_vv = 16'b0101_1111_1011_1100;   // cycles 2-5, 7-12, 14
        exp_ca = 16'b0010_0000_0100_0000;   // cycles 6, 13

        // Reset held two cycles with both requesters active
        bus.v_req = 1'b1; bus.v_addr = 12'h3FF;
        bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 12'h055; bus.c_wdata = 8'hAA;
        reset = 1'b1;
        for (int r = 0; r < 2; r++) begin
            cyc();
            chk($sformatf("rst%0d_v_valid", r), 32'(bus.v_valid), 32'd0);
            chk($sformatf("rst%0d_v_overrun", r), 32'(bus.v_overrun), 32'd0);
            chk($sformatf("rst%0d_c_ack", r), 32'(bus.c_ack), 32'd0);
            chk($sformatf("rst%0d_mem_a", r), 32'(bus.mem_a), 32'd0);
            chk($sformatf("rst%0d_mem_d", r), 32'(bus.mem_d), 32'd0);
            chk($sformatf("rst%0d_mem_w", r), 32'(bus.mem_w), 32'd0);
        end
        reset = 1'b0;
        bus.v_req = 1'b0; bus.c_req = 1'b0; bus.c_we = 1'b0;
        for (int r = 0; r < 3; r++) begin
            cyc();
            chk($sformatf("post%0d_v_valid", r), 32'(bus.v_valid), 32'd0);
            chk($sformatf("post%0d_c_ack", r), 32'(bus.c_ack), 32'd0);
            chk($sformatf("post%0d_mem_w", r), 32'(bus.mem_w), 32'd0);
        end

        // Uncontested video read
        bus.v_req = 1'b1; bus.v_addr = 12'h123;
        cyc();
        chk("vid_mem_a", 32'(bus.mem_a), 32'h123);
        chk("vid_mem_w", 32'(bus.mem_w), 32'd0);
        chk("vid_early_valid", 32'(bus.v_valid), 32'd0);
        bus.v_req = 1'b0;
        cyc();
        chk("vid_valid", 32'(bus.v_valid), 32'd1);
        chk("vid_data", 32'(bus.v_data), 32'h41);
        chk("vid_no_ack", 32'(bus.c_ack), 32'd0);
        cyc();
        chk("vid_valid_pulse", 32'(bus.v_valid), 32'd0);

        // CPU write then read back
        bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 12'h010; bus.c_wdata = 8'hB5;
        cyc();
        chk("wr_mem_w", 32'(bus.mem_w), 32'd1);
        chk("wr_mem_a", 32'(bus.mem_a), 32'h010);
        chk("wr_mem_d", 32'(bus.mem_d), 32'hB5);
        chk("wr_early_ack", 32'(bus.c_ack), 32'd0);
        cyc();
        chk("wr_ack", 32'(bus.c_ack), 32'd1);
        chk("wr_mem_w_once", 32'(bus.mem_w), 32'd0);
        chk("wr_no_vvalid", 32'(bus.v_valid), 32'd0);
        bus.c_req = 1'b0; bus.c_we = 1'b0;
        cyc();
        chk("wr_ack_pulse", 32'(bus.c_ack), 32'd0);
        bus.c_req = 1'b1;
        cyc();
        chk("rd_mem_a", 32'(bus.mem_a), 32'h010);
        chk("rd_mem_w", 32'(bus.mem_w), 32'd0);
        cyc();
        chk("rd_ack", 32'(bus.c_ack), 32'd1);
        chk("rd_data", 32'(bus.c_rdata), 32'hB5);
        bus.c_req = 1'b0;
        cyc();
        cyc();

        // Continuous video with CPU held: starvation slot, then overrun on second CPU slot
        for (int k = 0; k < 16; k++) begin
            if (k > 0) cyc();
            if (k >= 1 && k <= 13) chk($sformatf("s%0d_mem_a", k), 32'(bus.mem_a), 32'(exp_ma[k]));
            chk($sformatf("s%0d_mem_w", k), 32'(bus.mem_w), 32'd0);
            chk($sformatf("s%0d_v_valid", k), 32'(bus.v_valid), 32'(exp_vv[k]));
            chk($sformatf("s%0d_c_ack", k), 32'(bus.c_ack), 32'(exp_ca[k]));
            chk($sformatf("s%0d_v_overrun", k), 32'(bus.v_overrun), (k >= 12) ? 32'd1 : 32'd0);
            if (exp_vv[k]) chk($sformatf("s%0d_v_data", k), 32'(bus.v_data), 32'(ram_init(exp_ma[k-1])));
            if (exp_ca[k]) chk($sformatf("s%0d_c_rdata", k), 32'(bus.c_rdata), 32'hB5);
            bus.v_req  = (k <= 11);
            bus.v_addr = (k < 10) ? 12'h200 + 12'(k) : ((k == 10) ? 12'h001 : 12'h002);
            bus.c_req  = (k <= 13);
            bus.c_we   = 1'b0;
            bus.c_addr = 12'h010;
        end
        cyc();
        chk("overrun_sticky", 32'(bus.v_overrun), 32'd1);

        // Reset while a CPU read is in flight
        bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 12'h123;
        cyc();
        chk("mid_mem_a", 32'(bus.mem_a), 32'h123);
        reset = 1'b1; bus.c_req = 1'b0;
        cyc();
        chk("mid_no_ack", 32'(bus.c_ack), 32'd0);
        chk("mid_mem_a_rst", 32'(bus.mem_a), 32'd0);
        chk("mid_overrun_clr", 32'(bus.v_overrun), 32'd0);
        reset = 1'b0;
        for (int r = 0; r < 2; r++) begin
            cyc();
            chk($sformatf("mid_quiet%0d_ack", r), 32'(bus.c_ack), 32'd0);
        end
        bus.c_req = 1'b1;
        cyc();
        chk("rec_mem_a", 32'(bus.mem_a), 32'h123);
        cyc();
        chk("rec_ack", 32'(bus.c_ack), 32'd1);
        chk("rec_data", 32'(bus.c_rdata), 32'h41);
        bus.c_req = 1'b0;
        cyc();
        chk("rec_ack_pulse", 32'(bus.c_ack), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Shares one single-port text/character RAM between two requesters: the text video fetcher (read-only, latency-critical) and the CPU bus (read/write, req/ack handshake that drives core stall). The video port has fixed priority. A starvation counter guarantees the CPU a slot under continuous video traffic. The block sits between the core, the text adapter, and one port of the character RAM, which has a registered output and 1-cycle read latency.

Parameters:
AW, 12, address width (4K window)
DW, 8, data width
STARVE, 4, max consecutive video grants while CPU waits (range 1..255)

Ports:
clock    in   1   system clock
reset    in   1   synchronous, active-high reset
v_req    in   1   video read request, single-cycle pulse
v_addr   in   AW  video read address, sampled with v_req
v_valid  out  1   video data valid, one-cycle pulse
v_data   out  DW  video read data (mem_q passthrough; meaningful only when v_valid=1)
v_overrun out 1   sticky: an unserved video request was overwritten
c_req    in   1   CPU request, level, held until c_ack
c_we     in   1   CPU write enable, sampled with c_req
c_addr   in   AW  CPU address
c_wdata  in   DW  CPU write data
c_ack    out  1   CPU access complete, one-cycle pulse
c_rdata  out  DW  CPU read data (mem_q passthrough; meaningful only when c_ack=1 for a read)
mem_a    out  AW  RAM address (registered)
mem_d    out  DW  RAM write data (registered)
mem_w    out  1   RAM write strobe (registered)
mem_q    in   DW  RAM read data, valid 1 cycle after mem_a

Behaviour:
- Reset values: v_valid=0, v_overrun=0, c_ack=0, mem_a=0, mem_d=0, mem_w=0.
- Reset also clears the video pending slot, CPU busy flag, starve counter, and in-flight tags.
- Video slot (1 entry): v_req=1 captures v_addr.
  - If the slot is full and not granted this cycle, v_req overwrites it and sets v_overrun.
  - If the slot is granted in the same cycle that v_req arrives, the new request is captured with no overrun.
- CPU pending = c_req & ~c_busy & ~c_ack.
  - c_busy is set at grant and cleared on the c_ack cycle.
  - Minimum CPU cadence: 3 cycles per access.
- Arbitration each cycle, over candidates = video slot (or v_req this cycle) and CPU pending:
  - Only one candidate: grant it.
  - Both, starve_cnt < STARVE: grant video, starve_cnt += 1.
  - Both, starve_cnt == STARVE: grant CPU. Video stays pending.
  - Any CPU grant, or CPU not pending: starve_cnt = 0.
- Grant edge registers mem_a/mem_d/mem_w. mem_w=1 for exactly one cycle, only for a CPU write.
- Video latency, uncontested: v_req in cycle 0 -> mem_a=v_addr in cycle 1 -> v_valid=1 with v_data=mem_q in cycle 2.
- CPU latency, uncontested: c_req in cycle 0 -> mem op in cycle 1 -> c_ack in cycle 2, for both read and write.
- Back-to-back grants are allowed every cycle (pipelined). The return tag (video/CPU) is registered alongside mem_a.
- v_valid and c_ack are never high in the same cycle.
- Reset asserted mid-operation:
  - In-flight tags are discarded, so no v_valid/c_ack follows.
  - mem_w=0 from the cycle after the reset edge.
  - A write already presented on mem_w before reset stands.
- c_req deasserted before ack is a protocol violation; the access still completes and acks.

Test Plan:
- Reset held 2 cycles with c_req=v_req=1 -> all outputs 0; no mem_w; no v_valid/c_ack for 3 cycles after release with inputs low.
- RAM[0x123]=0x41; v_req cycle 0 addr 0x123 -> cycle 1 mem_a=0x123, mem_w=0; cycle 2 v_valid=1, v_data=0x41.
- CPU write 0xB5 to 0x010 -> mem_w=1 for 1 cycle with mem_a=0x010, mem_d=0xB5; c_ack in cycle 2. Then a read of 0x010 -> c_ack with c_rdata=0xB5.
- v_req every cycle, c_req held, STARVE=4 -> exactly 4 video grants, then a CPU grant, c_ack 2 cycles later; the deferred video request is granted the next cycle; starve_cnt restarts.
- Two v_req pulses (addr 0x001 then 0x002) while the CPU holds the grant cycle -> v_overrun=1 and stays 1; exactly one v_valid follows, for 0x002.
- CPU read granted (mem_a driven), reset asserted that cycle -> no c_ack; after release a new c_req completes normally in 2 cycles.
